// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV64 program-counter unit with priority redirect, stall, misalign detect and return-address stack
module pc_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              IALIGN_BITS = 2,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap,
    input  logic [XLEN-1:0] trapVec,
    input  logic            mret,
    input  logic [XLEN-1:0] epc,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] nextPc,
    output logic            misalign,
    output logic [XLEN-1:0] rasTop,
    output logic            rasValid,
    output logic            rasOverflow
);
    localparam int            PW   = $clog2(RAS_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [XLEN-1:0] seq_pc, jump_tgt, jalr_tgt, ctl_tgt, next_pc_c;
    logic            misalign_c, update, ras_en;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    always_comb begin
        seq_pc     = pc_q + XLEN'(4);
        jump_tgt   = pc_q + offset;
        jalr_tgt   = (rs1 + offset) & ~XLEN'(1);
        ctl_tgt    = jalr ? jalr_tgt : jump_tgt;
        misalign_c = (jalr | jump) & ~trap & ~mret & (|ctl_tgt[IALIGN_BITS-1:0]);

        if (trap)      next_pc_c = trapVec;
        else if (mret) next_pc_c = epc;
        else if (jalr) next_pc_c = jalr_tgt;
        else if (jump) next_pc_c = jump_tgt;
        else           next_pc_c = seq_pc;

        // trap/mret must redirect even from a stalled or faulting instruction
        update = trap | mret | (~stall & ~misalign_c);
        pc_d   = update ? next_pc_c : pc_q;
    end

    always_comb begin
        ras_en  = ~stall & ~misalign_c & ~trap & ~mret;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (ras_en) begin
            if (call && (!ret || count_q == '0)) begin
                // Full stack wraps onto its oldest slot, losing that prediction
                ptr_d  = ptr_q + PW'(1);
                wr_en  = 1'b1;
                wr_idx = ptr_q + PW'(1);
                if (count_q == FULL) ovf_d = 1'b1;
                else                 count_d = count_q + CW'(1);
            end else if (call && ret) begin
                wr_en = 1'b1;
            end else if (ret && count_q != '0) begin
                ptr_d   = ptr_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_en) ras_q[wr_idx] <= seq_pc;
        end
    end

    assign pc          = pc_q;
    assign nextPc      = next_pc_c;
    assign misalign    = misalign_c;
    assign rasValid    = (count_q != '0);
    assign rasTop      = rasValid ? ras_q[ptr_q] : '0;
    assign rasOverflow = ovf_q;
endmodule
